// File: rtl/ula_ar_pkg.sv
// Shared opcode encoding and helpers for the arithmetic ALU slice.
package ula_ar_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 5'b00000,
    OP_ADC = 5'b00001,
    OP_INC = 5'b00010,
    OP_SUB = 5'b00100,
    OP_SBC = 5'b00101,
    OP_DEC = 5'b00110,
    OP_NEG = 5'b00111,
    OP_CMP = 5'b01000,
    OP_PSA = 5'b01001
  } op_e;

  function automatic logic is_arith_op(input op_e op);
    case (op)
      OP_ADD, OP_ADC, OP_INC, OP_SUB, OP_SBC,
      OP_DEC, OP_NEG, OP_CMP, OP_PSA: is_arith_op = 1'b1;
      default:                        is_arith_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_ar_addsub.sv
// Combinational (WIDTH+1)-bit adder with optional addend inversion and signed overflow.
module ula_ar_addsub #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             invert_y,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_full;

  assign w_y    = invert_y ? ~y : y;
  assign w_full = {1'b0, x} + {1'b0, w_y} + {{WIDTH{1'b0}}, cin};
  assign sum    = w_full[WIDTH-1:0];
  assign cout   = w_full[WIDTH];
  // Overflow is judged against the post-inversion addend.
  assign ovf    = (x[WIDTH-1] == w_y[WIDTH-1]) && (w_full[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/ula_ar.sv
// Arithmetic ALU: opcode decode, operand muxing and registered result/flags.
module ula_ar
  import ula_ar_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  OP,
  output logic [WIDTH-1:0] RESU,
  output logic             O,
  output logic             C,
  output logic             S,
  output logic             Z
);

  logic [WIDTH-1:0] r_resu;
  logic             r_o;
  logic             r_c;
  logic             r_s;
  logic             r_z;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic             w_inv;
  logic             w_wr_res;
  logic             w_psa;
  logic             w_legal;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_one;

  assign w_one   = {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_legal = is_arith_op(op_e'(OP));

  always_comb begin
    w_x      = A;
    w_y      = B;
    w_cin    = 1'b0;
    w_inv    = 1'b0;
    w_wr_res = 1'b1;
    w_psa    = 1'b0;
    case (op_e'(OP))
      OP_ADD: begin end
      OP_ADC: w_cin = r_c;
      OP_INC: w_y = w_one;
      OP_SUB: begin w_inv = 1'b1; w_cin = 1'b1; end
      OP_SBC: begin w_inv = 1'b1; w_cin = r_c; end
      OP_DEC: begin w_y = w_one; w_inv = 1'b1; w_cin = 1'b1; end
      OP_NEG: begin w_x = {WIDTH{1'b0}}; w_y = A; w_inv = 1'b1; w_cin = 1'b1; end
      // CMP computes the difference for the flags but leaves RESU alone.
      OP_CMP: begin w_inv = 1'b1; w_cin = 1'b1; w_wr_res = 1'b0; end
      OP_PSA: w_psa = 1'b1;
      default: w_wr_res = 1'b0;
    endcase
  end

  ula_ar_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x        (w_x),
    .y        (w_y),
    .cin      (w_cin),
    .invert_y (w_inv),
    .sum      (w_sum),
    .cout     (w_cout),
    .ovf      (w_ovf)
  );

  assign w_res = w_psa ? A : w_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resu <= {WIDTH{1'b0}};
      r_o    <= 1'b0;
      r_c    <= 1'b0;
      r_s    <= 1'b0;
      r_z    <= 1'b0;
    end else if (en && w_legal) begin
      if (w_wr_res) begin
        r_resu <= w_res;
      end
      r_o <= w_psa ? 1'b0 : w_ovf;
      r_c <= w_psa ? 1'b0 : w_cout;
      r_s <= w_res[WIDTH-1];
      r_z <= (w_res == {WIDTH{1'b0}});
    end
  end

  assign RESU = r_resu;
  assign O    = r_o;
  assign C    = r_c;
  assign S    = r_s;
  assign Z    = r_z;

endmodule

// File: tb/tb_ula_ar.sv
// Scoreboard bench for ula_ar (WIDTH=3): directed vectors, expectations queued, monitor compares.
module tb_ula_ar;

  localparam int WIDTH = 3;

  typedef struct {
    string      name;
    logic [6:0] exp;   // {RESU[2:0], O, C, S, Z}
  } item_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       OP;
  logic [WIDTH-1:0] RESU;
  logic             O;
  logic             C;
  logic             S;
  logic             Z;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  ula_ar #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .OP    (OP),
    .RESU  (RESU),
    .O     (O),
    .C     (C),
    .S     (S),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector at the falling edge; its result is due at the next rising edge.
  task automatic apply(input string name, input logic rn, input logic e,
                       input logic [2:0] a, input logic [2:0] b, input logic [4:0] op,
                       input logic [6:0] exp);
    item_t it;
    @(negedge clk);
    rst_n = rn;
    en    = e;
    A     = a;
    B     = b;
    OP    = op;
    it.name = name;
    it.exp  = exp;
    q.push_back(it);
  endtask

  // Monitor: one registered response per rising edge while expectations are pending.
  initial begin
    item_t it;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {RESU, O, C, S, Z};
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got RESU=%b O=%b C=%b S=%b Z=%b, want RESU=%b O=%b C=%b S=%b Z=%b",
                   it.name, act[6:4], act[3], act[2], act[1], act[0],
                   it.exp[6:4], it.exp[3], it.exp[2], it.exp[1], it.exp[0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    A     = 3'b000;
    B     = 3'b000;
    OP    = 5'b00000;
    //     name              rst  en   A       B       OP          RESU  O C S Z
    apply("reset1",         1'b0, 1'b1, 3'b011, 3'b001, 5'b00000, 7'b000_0000);
    apply("reset2",         1'b0, 1'b0, 3'b011, 3'b001, 5'b00000, 7'b000_0000);
    apply("hold_after_rst", 1'b1, 1'b0, 3'b011, 3'b001, 5'b00000, 7'b000_0000);
    apply("sub_3_1",        1'b1, 1'b1, 3'b011, 3'b001, 5'b00100, 7'b010_0100);
    apply("hold_en0",       1'b1, 1'b0, 3'b011, 3'b001, 5'b00000, 7'b010_0100);
    apply("add_ovf",        1'b1, 1'b1, 3'b011, 3'b001, 5'b00000, 7'b100_1010);
    apply("sub_neg_ovf",    1'b1, 1'b1, 3'b100, 3'b001, 5'b00100, 7'b011_1100);
    apply("sub_zero",       1'b1, 1'b1, 3'b001, 3'b001, 5'b00100, 7'b000_0101);
    apply("adc_c1",         1'b1, 1'b1, 3'b001, 3'b001, 5'b00001, 7'b011_0000);
    apply("sub_borrow",     1'b1, 1'b1, 3'b000, 3'b001, 5'b00100, 7'b111_0010);
    apply("neg_min",        1'b1, 1'b1, 3'b100, 3'b000, 5'b00111, 7'b100_1010);
    apply("cmp_eq",         1'b1, 1'b1, 3'b010, 3'b010, 5'b01000, 7'b100_0101);
    apply("illegal_hold",   1'b1, 1'b1, 3'b001, 3'b001, 5'b11111, 7'b100_0101);
    apply("sbc_c1",         1'b1, 1'b1, 3'b010, 3'b001, 5'b00101, 7'b001_0100);
    apply("inc_ovf",        1'b1, 1'b1, 3'b011, 3'b000, 5'b00010, 7'b100_1010);
    apply("dec_zero",       1'b1, 1'b1, 3'b000, 3'b000, 5'b00110, 7'b111_0010);
    apply("psa",            1'b1, 1'b1, 3'b101, 3'b011, 5'b01001, 7'b101_0010);
    apply("sub_b0",         1'b1, 1'b1, 3'b001, 3'b000, 5'b00100, 7'b001_0100);
    apply("mid_reset",      1'b0, 1'b1, 3'b001, 3'b001, 5'b00001, 7'b000_0000);
    apply("adc_after_rst",  1'b1, 1'b1, 3'b001, 3'b001, 5'b00001, 7'b010_0000);
    apply("sbc_c0",         1'b1, 1'b1, 3'b010, 3'b001, 5'b00101, 7'b000_0101);
    apply("rst_beats_en0",  1'b0, 1'b0, 3'b111, 3'b111, 5'b00000, 7'b000_0000);
    // Let the monitor drain, bounded by a cycle budget.
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
